fetch_mem_arbiter: RTL

Run controller and single-port memory arbiter for the pipelined core. It turns the `trigger` input into a start/halt fetch sequence and shares one unified memory port between instruction fetch and data load/store. Each transaction is a request followed by a `mem_rvalid` response. It also drives the fetch-stage stall that gates the PC and the F/D pipeline register.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_mem_arbiter_rr_arb2.sv | 33 +++
 rtl/fetch_mem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch/memory arbiter
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READY   = 3'd1,
        S_IF_WAIT = 3'd2,
        S_D_WAIT  = 3'd3,
        S_HALT    = 3'd4
    } fetch_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_mem_arbiter_rr_arb2.sv
// rtl/fetch_mem_arbiter_rr_arb2.sv - two-requester round-robin arbiter (fetch vs data)
module rr_arb2
    import fetch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_fetch,
    input  logic req_data,
    input  logic accept,
    output logic grant_data
);

    grant_t last_grant;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_data = 1'b0;
        if (req_fetch && req_data) begin
            grant_data = (last_grant == FETCH);
        end else if (req_data) begin
            grant_data = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= FETCH;
        end else if (accept) begin
            last_grant <= grant_t'(grant_data);
        end
    end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// rtl/fetch_mem_arbiter.sv - run controller and shared memory port arbiter for fetch and load/store
module fetch_mem_arbiter
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trigger,
    input  logic                  halt,
    input  logic                  PCSrcD,
    input  logic [ADDR_WIDTH-1:0] PCF,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] InstrF,
    output logic                  instr_valid,
    output logic                  StallFetch,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done
);

    fetch_state_t state;
    logic         discard;
    logic         halt_latched;
    logic         grant_data;
    logic         stop_now;

    // The fetch is always pending in READY, so any non-halted READY cycle issues a request.
    assign mem_req   = (state == S_READY) && !halt;
    assign mem_addr  = grant_data ? d_addr : PCF;
    assign mem_we    = mem_req && grant_data && d_we;
    assign mem_wdata = grant_data ? d_wdata : '0;
    assign stop_now  = halt || halt_latched;

    assign StallFetch = ~instr_valid;

    rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_fetch  (!halt),
        .req_data   (d_req && !halt),
        .accept     (mem_req),
        .grant_data (grant_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            InstrF       <= '0;
            d_rdata      <= '0;
            instr_valid  <= 1'b0;
            d_done       <= 1'b0;
            discard      <= 1'b0;
            halt_latched <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            d_done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        state <= S_READY;
                    end
                end
                S_READY: begin
                    if (halt) begin
                        state <= S_HALT;
                    end else if (grant_data) begin
                        state <= S_D_WAIT;
                    end else begin
                        state   <= S_IF_WAIT;
                        // A redirect alongside a delivered instruction belongs to the F/D flush.
                        discard <= PCSrcD && !instr_valid;
                    end
                end
                S_IF_WAIT: begin
                    if (halt) begin
                        halt_latched <= 1'b1;
                    end
                    if (PCSrcD) begin
                        discard <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        discard <= 1'b0;
                        if (!(discard || PCSrcD || stop_now)) begin
                            InstrF      <= mem_rdata;
                            instr_valid <= 1'b1;
                        end
                        state <= stop_now ? S_HALT : S_READY;
                    end
                end
                S_D_WAIT: begin
                    if (halt) begin
                        halt_latched <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        d_rdata <= mem_rdata;
                        d_done  <= 1'b1;
                        state   <= stop_now ? S_HALT : S_READY;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
